// File: rtl/pipe_skid_reg.sv
// Pipeline register stage with optional two-entry skid buffer.
// SKID=1 gives a registered in_ready; SKID=0 is a single-entry stage.
module pipe_skid_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter bit               SKID    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    if (SKID) begin : g_skid

        state_t           state_q;
        state_t           state_d;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;
        logic             in_ready_q;
        logic             in_xfer;
        logic             out_xfer;
        logic             load_main_in;
        logic             load_main_skid;
        logic             load_skid;

        assign in_xfer  = in_valid & in_ready_q;
        assign out_xfer = (state_q != EMPTY) & out_ready;

        // Next state and register-load selects; flush overrides the handshake.
        always_comb begin
            state_d        = state_q;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
            if (flush) begin
                state_d = EMPTY;
            end else begin
                unique case (state_q)
                    EMPTY: begin
                        if (in_xfer) begin
                            state_d      = ONE;
                            load_main_in = 1'b1;
                        end
                    end
                    ONE: begin
                        if (in_xfer && out_xfer) begin
                            load_main_in = 1'b1;
                        end else if (in_xfer) begin
                            state_d   = TWO;
                            load_skid = 1'b1;
                        end else if (out_xfer) begin
                            state_d = EMPTY;
                        end
                    end
                    TWO: begin
                        if (out_ready) begin
                            state_d        = ONE;
                            load_main_skid = 1'b1;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end

        // State register; in_ready is precomputed so it comes straight off a flop.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= EMPTY;
                in_ready_q <= 1'b1;
            end else begin
                state_q    <= state_d;
                in_ready_q <= (state_d != TWO);
            end
        end

        // Payload registers; flush leaves them untouched.
        always_ff @(posedge clk) begin
            if (rst) begin
                main_q <= RST_VAL;
                skid_q <= RST_VAL;
            end else begin
                if (load_main_in) begin
                    main_q <= in_data;
                end else if (load_main_skid) begin
                    main_q <= skid_q;
                end
                if (load_skid) begin
                    skid_q <= in_data;
                end
            end
        end

        assign in_ready  = in_ready_q;
        assign out_valid = (state_q != EMPTY);
        assign out_data  = main_q;
        assign count     = state_q;

    end else begin : g_single

        logic             valid_q;
        logic [WIDTH-1:0] main_q;
        logic             rdy;

        assign rdy = ~valid_q | out_ready;

        // Single entry: refill on accept, drain on delivery without refill.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                main_q  <= RST_VAL;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (in_valid && rdy) begin
                valid_q <= 1'b1;
                main_q  <= in_data;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end

        assign in_ready  = rdy;
        assign out_valid = valid_q;
        assign out_data  = main_q;
        assign count     = {1'b0, valid_q};

    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter RST_VAL, default {WIDTH{1'b0}}, value loaded into every data register on reset.
REQ-003 SHALL have parameter SKID, default 1; 1 = two-entry skid stage with registered in_ready, 0 = single-entry stage with combinational in_ready.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous discard of all held entries (pipeline kill).
REQ-007 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-008 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-009 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-011 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-012 SHALL have port out_data  output  WIDTH  oldest held entry, registered.
REQ-013 SHALL have port count  output  2  number of valid entries held (0..2 for SKID=1, 0..1 for SKID=0).

Function
REQ-014 SHALL treat an input transfer as in_valid & in_ready and an output transfer as out_valid & out_ready, both on the same rising edge.
REQ-015 SHALL deliver entries in acceptance order, with no loss, duplication or reordering, except entries discarded by flush or rst.
REQ-016 SHALL make an accepted entry visible on out_data/out_valid in the cycle after acceptance (latency 1); no combinational in_data->out_data path.
REQ-017 SHALL (SKID=1) hold a main register (drives out_data) and a skid register, with states EMPTY (count 0), ONE (count 1), TWO (count 2).
REQ-018 SHALL (SKID=1) drive in_ready = 1 in EMPTY and ONE, 0 in TWO, from a flop only; in_ready never depends combinationally on out_ready.
REQ-019 SHALL (SKID=1) transition EMPTY + input transfer -> ONE, main <= in_data.
REQ-020 SHALL (SKID=1) transition ONE + input and output transfer -> ONE, main <= in_data (full throughput, one entry per cycle).
REQ-021 SHALL (SKID=1) transition ONE + input transfer, no output transfer -> TWO, skid <= in_data, main unchanged.
REQ-022 SHALL (SKID=1) transition ONE + output transfer, no input transfer -> EMPTY.
REQ-023 SHALL (SKID=1) transition TWO + out_ready -> ONE, main <= skid; TWO + ~out_ready -> TWO, both registers held.
REQ-024 SHALL (SKID=0) drive in_ready = ~out_valid | out_ready combinationally; input transfer loads main and sets out_valid; output transfer without input transfer clears out_valid.
REQ-025 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, on flush=1, enter EMPTY (count 0, out_valid 0, in_ready 1) next cycle, discarding held entries and any input transfer in the flush cycle; an output transfer in the flush cycle still counts as delivered.
REQ-027 SHALL leave data registers unchanged on flush; out_data is don't-care while out_valid=0.
REQ-028 SHALL give priority rst > flush > normal handshake.

Reset
REQ-029 SHALL, with rst=1 at a rising edge, set out_valid=0, count=0, in_ready=1 (SKID=1), main and skid = RST_VAL, regardless of other inputs.
REQ-030 SHALL, on rst mid-operation (ONE or TWO), discard all entries exactly as REQ-029, with no entry appearing on out_valid after rst deasserts until a new input transfer.

Verification
REQ-031 SHALL cover: RST_VAL=32'hDEAD_BEEF, rst=1 one cycle -> out_valid=0, count=0, in_ready=1, out_data=32'hDEAD_BEEF.
REQ-032 SHALL cover: SKID=1, in_valid=1 every cycle with data 1,2,3,...,100, out_ready=1 -> out_data 1..100 on consecutive cycles, first one cycle after acceptance, count stays 1.
REQ-033 SHALL cover: SKID=1, accept 0xA then 0xB with out_ready=0 -> count=2, in_ready=0, out_data=0xA; raise out_ready -> 0xA then 0xB delivered, in_ready=1 one cycle after first release.
REQ-034 SHALL cover: count=2 (0x1, 0x2), flush=1 with in_valid=1 in_data=0x3 -> next cycle count=0, out_valid=0; 0x3 never appears.
REQ-035 SHALL cover: SKID=0, out_ready=0 with valid entry 0x5 held -> in_ready=0; out_ready=1 and in_valid=1 data 0x6 same cycle -> 0x5 delivered, out_data=0x6 next cycle.
REQ-036 SHALL cover: random in_valid/out_ready (50% each, 10k cycles, both SKID values) against a reference FIFO model -> zero ordering/loss mismatches, count never exceeds 2 (SKID=1) or 1 (SKID=0).
